// File: rtl/rom_stream_pkg.sv
// Shared FSM state type and default geometry for the ROM burst reader.
package rom_stream_pkg;
   localparam int DEF_ADDR_W     = 3;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/rom_stream_fifo.sv
// Synchronous FIFO with registered storage and pointers.
// A pushed entry becomes visible at the head one cycle later.
module rom_stream_fifo
   import rom_stream_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W + 1,
   parameter int DEPTH = DEF_FIFO_DEPTH,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en, rd_en;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   // A push into a full FIFO is still legal when the head leaves in the same cycle.
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   assign count_d = count_q + CW'(wr_en) - CW'(rd_en);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   assign pop_dat_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer in front of a 1-cycle ROM; first byte 3 cycles after start, reads pause when FIFO credit runs out.
// Define ROM_STREAM_CSUM_EN to add the csum_o running byte checksum.
module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [ADDR_W:0]   len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              rom_enb_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic              m_valid_o,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_last_o,
   input  logic              m_ready_i
`ifdef ROM_STREAM_CSUM_EN
  ,output logic [DATA_W-1:0] csum_o
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              rom_enb_q, rom_enb_d;
   logic              done_q, done_d;
   logic              inflight_q, last_inflight_q;
   logic              fifo_full, fifo_empty, pop;
   logic [DATA_W:0]   fifo_head;
   logic [CW-1:0]     fifo_count;
   logic [SW-1:0]     credit_use;

   assign pop = !fifo_empty && m_ready_i;
   // rom_enb is registered, so credit is judged on next cycle's occupancy plus in-flight reads.
   assign credit_use = SW'(fifo_count) + SW'(inflight_q) + SW'(rom_enb_q) - SW'(pop);

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      remaining_d = remaining_q;
      rom_enb_d   = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  rom_addr_d  = start_addr_i;
                  remaining_d = len_i;
                  rom_enb_d   = 1'b1;
                  state_d     = ST_READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (rom_enb_q) begin
               rom_addr_d  = rom_addr_q + ADDR_W'(1);
               remaining_d = remaining_q - (ADDR_W + 1)'(1);
               if (remaining_q == (ADDR_W + 1)'(1)) state_d = ST_DRAIN;
            end
            rom_enb_d = (state_d == ST_READ) && (credit_use < SW'(FIFO_DEPTH));
         end
         ST_DRAIN: begin
            if (pop && fifo_head[DATA_W]) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q         <= ST_IDLE;
         rom_addr_q      <= '0;
         remaining_q     <= '0;
         rom_enb_q       <= 1'b0;
         done_q          <= 1'b0;
         inflight_q      <= 1'b0;
         last_inflight_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         rom_addr_q      <= rom_addr_d;
         remaining_q     <= remaining_d;
         rom_enb_q       <= rom_enb_d;
         done_q          <= done_d;
         inflight_q      <= rom_enb_q;
         last_inflight_q <= rom_enb_q && (remaining_q == (ADDR_W + 1)'(1));
      end
   end

   rom_stream_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .push_i     (inflight_q),
      .push_dat_i ({last_inflight_q, rom_data_i}),
      .pop_i      (pop),
      .pop_dat_o  (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assert property (@(posedge clk_i) disable iff (!rst_n_i) !(fifo_full && inflight_q));

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = done_q;
   assign rom_enb_o  = rom_enb_q;
   assign rom_addr_o = rom_addr_q;
   assign m_valid_o  = !fifo_empty;
   assign m_data_o   = fifo_head[DATA_W-1:0];
   assign m_last_o   = !fifo_empty && fifo_head[DATA_W];

`ifdef ROM_STREAM_CSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == ST_IDLE && start_i) csum_d = '0;
      else if (pop)                      csum_d = csum_q + m_data_o;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) csum_q <= '0;
      else          csum_q <= csum_d;
   end

   assign csum_o = csum_q;
`else
   // Checksum accumulator not built.
`endif
endmodule
